b3_digit_halfadder: RTL and testbench

- Base-3 half adder (incrementer): adds a 1-bit carry-in to a base-3 number held as 2-bit digit codes.
- Produces the base-3 sum digits and a carry-out.
- Primary client is the base-3 up counter, which uses the default configuration as its combinational next-state incrementer (digit in = counter state, cin = count enable, cout = ripple enable to the next digit).
- An optional output register stage supports pipelined use.

---
 rtl/b3_digit_halfadder_if.sv | 27 ++
 rtl/b3_digit_halfadder.sv | 75 +++++++
 tb/tb_b3_digit_halfadder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/b3_digit_halfadder_if.sv
// Operand/result bundle for the base-3 digit incrementer.
// The master drives the operand and carry-in; the slave returns sum, carry-out and error.
interface b3_digit_halfadder_if #(
    parameter int DIGITS = 1
);
    logic [2*DIGITS-1:0] x1_x0;
    logic                cin;
    logic [2*DIGITS-1:0] s1_s0;
    logic                cout;
    logic                err;

    modport master (
        output x1_x0,
        output cin,
        input  s1_s0,
        input  cout,
        input  err
    );

    modport slave (
        input  x1_x0,
        input  cin,
        output s1_s0,
        output cout,
        output err
    );
endinterface

// File: rtl/b3_digit_halfadder.sv
// Base-3 incrementer: adds a 1-bit carry-in to a number stored as 2-bit digit codes
// (00=0, 01=1, 10=2), rippling carries digit by digit, with an optional output register.
module b3_digit_halfadder #(
    parameter int DIGITS  = 1,
    parameter bit REG_OUT = 1'b0
) (
    input  logic                    clock,
    input  logic                    reset_,
    b3_digit_halfadder_if.slave     bus
);
    logic [DIGITS:0]        carry;
    logic [DIGITS-1:0]      bad_digit;
    logic [2*DIGITS-1:0]    sum_raw;
    logic [2*DIGITS-1:0]    sum_next;
    logic                   cout_next;
    logic                   err_next;

    assign carry[0] = bus.cin;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic [1:0] digit;
        logic [1:0] sum_digit;

        assign digit        = bus.x1_x0[2*gi +: 2];
        assign bad_digit[gi] = &digit;
        assign carry[gi+1]  = carry[gi] & (digit == 2'b10);

        always_comb begin
            sum_digit = digit;
            if (carry[gi]) begin
                case (digit)
                    2'b00:   sum_digit = 2'b01;
                    2'b01:   sum_digit = 2'b10;
                    default: sum_digit = 2'b00;
                endcase
            end
        end

        assign sum_raw[2*gi +: 2] = sum_digit;
    end

    // Any invalid digit poisons the whole result so code 11 can never reach the output.
    assign err_next  = |bad_digit;
    assign sum_next  = err_next ? '0 : sum_raw;
    assign cout_next = ~err_next & carry[DIGITS];

    if (REG_OUT) begin : g_reg
        logic [2*DIGITS-1:0] sum_reg;
        logic                cout_reg;
        logic                err_reg;

        always_ff @(posedge clock or negedge reset_) begin
            if (!reset_) begin
                sum_reg  <= '0;
                cout_reg <= 1'b0;
                err_reg  <= 1'b0;
            end else begin
                sum_reg  <= sum_next;
                cout_reg <= cout_next;
                err_reg  <= err_next;
            end
        end

        assign bus.s1_s0 = sum_reg;
        assign bus.cout  = cout_reg;
        assign bus.err   = err_reg;
    end else begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, clock, reset_};

        assign bus.s1_s0 = sum_next;
        assign bus.cout  = cout_next;
        assign bus.err   = err_next;
    end
endmodule

// File: tb/tb_b3_digit_halfadder.sv
// Self-checking bench: combinational 1- and 3-digit instances, a registered 2-digit instance
// checked through a scoreboard queue, and a 1-digit counter loop built around the incrementer.
module tb_b3_digit_halfadder;
    logic clock = 1'b0;
    logic reset_;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    b3_digit_halfadder_if #(.DIGITS(1)) if_c1 ();
    b3_digit_halfadder_if #(.DIGITS(3)) if_c3 ();
    b3_digit_halfadder_if #(.DIGITS(2)) if_r2 ();

    b3_digit_halfadder #(.DIGITS(1), .REG_OUT(1'b0)) dut_c1 (.clock(clock), .reset_(reset_), .bus(if_c1.slave));
    b3_digit_halfadder #(.DIGITS(3), .REG_OUT(1'b0)) dut_c3 (.clock(clock), .reset_(reset_), .bus(if_c3.slave));
    b3_digit_halfadder #(.DIGITS(2), .REG_OUT(1'b1)) dut_r2 (.clock(clock), .reset_(reset_), .bus(if_r2.slave));

    // Expected result packed as {err, cout, s[31:0]}.
    logic [33:0] exp_q[$];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: interpret digits as an integer, add cin, reduce modulo 3^d.
    function automatic logic [33:0] ref_model(int d, logic [31:0] x, logic c);
        int unsigned val = 0;
        int unsigned modv = 1;
        int unsigned total;
        logic        bad = 1'b0;
        logic        co;
        logic [31:0] s = '0;
        for (int i = d - 1; i >= 0; i--) begin
            logic [1:0] dg;
            dg = x[2*i +: 2];
            if (dg == 2'd3) bad = 1'b1;
            val  = val * 3 + dg;
            modv = modv * 3;
        end
        total = val + c;
        co    = (total == modv);
        total = total % modv;
        for (int i = 0; i < d; i++) begin
            s[2*i +: 2] = 2'(total % 3);
            total = total / 3;
        end
        if (bad) return {1'b1, 1'b0, 32'd0};
        return {1'b0, co, s};
    endfunction

    function automatic logic [33:0] pack_r2();
        return {if_r2.err, if_r2.cout, 28'd0, if_r2.s1_s0};
    endfunction

    // Scoreboard monitor: the registered instance presents a result after every edge.
    initial begin
        logic [33:0] e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("reg_stream", 64'(pack_r2()), 64'(e));
            end
        end
    end

    initial begin
        logic [33:0] e;
        logic [33:0] last_exp;
        logic [1:0]  cnt;
        int          wait_cnt;

        reset_      = 1'b0;
        if_c1.x1_x0 = '0; if_c1.cin = 1'b0;
        if_c3.x1_x0 = '0; if_c3.cin = 1'b0;
        if_r2.x1_x0 = 4'b1010; if_r2.cin = 1'b1;

        // Registered outputs stay clear across edges while in reset.
        repeat (3) @(posedge clock);
        #1 check("reset_state", 64'(pack_r2()), 64'd0);

        // 1-digit combinational, exhaustive including invalid code.
        for (int xv = 0; xv < 4; xv++) begin
            for (int cv = 0; cv < 2; cv++) begin
                if_c1.x1_x0 = 2'(xv);
                if_c1.cin   = cv[0];
                #1;
                e = ref_model(1, 32'(xv), cv[0]);
                check($sformatf("c1_x%0d_c%0d", xv, cv),
                      64'({if_c1.err, if_c1.cout, 30'd0, if_c1.s1_s0}), 64'(e));
            end
        end

        // 3-digit combinational: ripple and wrap cases, then random operands.
        for (int k = 0; k < 36; k++) begin
            logic [5:0] xv;
            logic       cv;
            case (k)
                0: begin xv = 6'b10_10_10; cv = 1'b1; end
                1: begin xv = 6'b01_10_10; cv = 1'b1; end
                2: begin xv = 6'b01_10_10; cv = 1'b0; end
                default: begin xv = 6'($urandom); cv = 1'($urandom); end
            endcase
            if_c3.x1_x0 = xv;
            if_c3.cin   = cv;
            #1;
            e = ref_model(3, 32'(xv), cv);
            check($sformatf("c3_x%b_c%0d", xv, cv),
                  64'({if_c3.err, if_c3.cout, 26'd0, if_c3.s1_s0}), 64'(e));
        end

        // Registered instance: first capture after release, then a random stream.
        @(negedge clock);
        reset_      = 1'b1;
        last_exp    = '0;
        for (int k = 0; k < 40; k++) begin
            logic [3:0] xv;
            logic       cv;
            if (k == 0) begin xv = 4'b00_10; cv = 1'b1; end
            else begin xv = 4'($urandom); cv = 1'($urandom); end
            if_r2.x1_x0 = xv;
            if_r2.cin   = cv;
            e = ref_model(2, 32'(xv), cv);
            exp_q.push_back(e);
            #1 check("reg_hold_before_edge", 64'(pack_r2()), 64'(last_exp));
            last_exp = e;
            @(negedge clock);
        end

        // Capture a known non-zero value, then assert reset mid-cycle.
        if_r2.x1_x0 = 4'b00_10;
        if_r2.cin   = 1'b1;
        exp_q.push_back(ref_model(2, 32'h2, 1'b1));
        @(posedge clock);
        #3;
        if_r2.x1_x0 = 4'b10_10;
        reset_      = 1'b0;
        #1 check("reset_async", 64'(pack_r2()), 64'd0);
        repeat (2) begin
            @(posedge clock);
            #1 check("reset_hold", 64'(pack_r2()), 64'd0);
        end
        @(negedge clock);
        reset_ = 1'b1;
        exp_q.push_back({1'b0, 1'b1, 32'd0});

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(negedge clock);
            wait_cnt++;
        end
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        // Counter loop: 1-digit incrementer feeding a 2-bit state register.
        cnt         = 2'd0;
        if_c1.cin   = 1'b1;
        if_c1.x1_x0 = cnt;
        @(negedge clock);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("counter_state_%0d", k), 64'(cnt), 64'(k % 3));
            check($sformatf("counter_cout_%0d", k), 64'(if_c1.cout), 64'(k % 3 == 2));
            @(posedge clock);
            cnt         = if_c1.s1_s0;
            if_c1.x1_x0 = cnt;
            @(negedge clock);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
